sync_fifo_flags: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the 16-bit sync FIFO.
//  - Generic width and depth; fill-level count; programmable almost-full/almost-empty flags.
//  - Sticky overflow/underflow error flags.
//  - Optional first-word-fall-through (FWFT) read mode.
//  - Sits between producer/consumer stages in the kernel datapath, same clock domain.

---
 rtl/sync_fifo_pkg.sv | 42 ++++
 rtl/sync_fifo_ram.sv | 47 ++++
 rtl/sync_fifo_flags.sv | 169 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised single-clock FIFO.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
package sync_fifo_pkg;

  // Width of a counter able to hold 0..depth inclusive
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Legal parameter set: power-of-two depth >= 2, thresholds inside the fill range
  function automatic bit params_ok(input int unsigned dwidth,
                                   input int unsigned depth,
                                   input int unsigned af_level,
                                   input int unsigned ae_level);
    return (dwidth >= 1) &&
           (depth >= 2) &&
           ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 1);
  endfunction

  // Registered FIFO status bits
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Status after reset: nothing stored, no errors
  localparam fifo_status_t STATUS_RESET = '{
    empty:        1'b1,
    full:         1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DWIDTH storage array, one write port and one read port.
// Build option SYNC_FIFO_FWFT_EN: read port is combinational (the top
// registers the head word itself); otherwise the read port is registered.
module sync_fifo_ram #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic                       i_rst,
  input  logic                       i_rd_en,
`endif
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DWIDTH-1:0]          i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DWIDTH-1:0]          o_rdata
);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Asynchronous read of the addressed entry
  assign o_rdata = r_mem[i_raddr];
`else
  logic [DWIDTH-1:0] r_rdata;

  // Registered read: output only changes on a pop, clears on reset
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with fill count, programmable almost
// flags and sticky overflow/underflow errors.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through mode,
// where the head word sits in an output register and rd_en acts as an ack.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter  int unsigned DWIDTH   = 16,
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned AF_LEVEL = 14,
  parameter  int unsigned AE_LEVEL = 2,
  localparam int unsigned CW       = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] din,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam int unsigned   PW       = AW + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  // Reject illegal parameter sets at elaboration
  if (!params_ok(DWIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_flags: illegal DWIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  fifo_status_t      r_status;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_mem_we;
  logic              w_rptr_inc;
  logic [PW-1:0]     w_wptr_nxt;
  logic [PW-1:0]     w_rptr_nxt;
  logic [CW-1:0]     w_count_nxt;
  fifo_status_t      w_status_nxt;
  logic [DWIDTH-1:0] w_ram_rdata;

`ifdef SYNC_FIFO_FWFT_EN
  logic              r_dout_vld;
  logic [DWIDTH-1:0] r_dout;
  logic              w_out_free;
  logic              w_mem_empty;
  logic              w_load_mem;
  logic              w_load_din;
  logic              w_dout_vld_nxt;
`endif

  // Accept decisions, pointer/count advance and next-state flags
  always_comb begin
    w_wr_acc     = wr_en && !r_status.full;
    w_rd_acc     = rd_en && !r_status.empty;
    w_mem_we     = 1'b0;
    w_rptr_inc   = 1'b0;
    w_status_nxt = r_status;
    w_count_nxt  = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

`ifdef SYNC_FIFO_FWFT_EN
    // Output register refills from memory first; a write into a totally
    // empty FIFO goes straight to the output register.
    w_out_free     = !r_dout_vld || w_rd_acc;
    w_mem_empty    = (r_wptr == r_rptr);
    w_load_mem     = w_out_free && !w_mem_empty;
    w_load_din     = w_out_free && w_mem_empty && w_wr_acc;
    w_mem_we       = w_wr_acc && !w_load_din;
    w_rptr_inc     = w_load_mem;
    w_dout_vld_nxt = w_load_mem || w_load_din || (r_dout_vld && !w_rd_acc);
`else
    w_mem_we       = w_wr_acc;
    w_rptr_inc     = w_rd_acc;
`endif

    w_wptr_nxt = w_mem_we   ? (r_wptr + PW'(1)) : r_wptr;
    w_rptr_nxt = w_rptr_inc ? (r_rptr + PW'(1)) : r_rptr;

`ifdef SYNC_FIFO_FWFT_EN
    // Occupancy includes the output register
    w_status_nxt.empty = !w_dout_vld_nxt;
    w_status_nxt.full  = (w_count_nxt == CW'(DEPTH));
`else
    w_status_nxt.empty = (w_wptr_nxt == w_rptr_nxt);
    w_status_nxt.full  = ((w_wptr_nxt ^ w_rptr_nxt) == FULL_XOR);
`endif

    w_status_nxt.almost_empty = (w_count_nxt <= CW'(AE_LEVEL));
    w_status_nxt.almost_full  = (w_count_nxt >= CW'(AF_LEVEL));
    // Sticky errors: a new error in the clearing cycle wins
    w_status_nxt.overflow  = (wr_en && r_status.full) ||
                             (r_status.overflow && !err_clr);
    w_status_nxt.underflow = (rd_en && r_status.empty) ||
                             (r_status.underflow && !err_clr);
  end

  // Pointer, count and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_status <= STATUS_RESET;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_status <= w_status_nxt;
    end
  end

  sync_fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .i_rst   (rst),
    .i_rd_en (w_rd_acc),
`endif
    .i_we    (w_mem_we),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (din),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Output stage holding the head word; keeps its last value once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_vld <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_dout_vld <= w_dout_vld_nxt;
      if (w_load_mem) begin
        r_dout <= w_ram_rdata;
      end else if (w_load_din) begin
        r_dout <= din;
      end
    end
  end

  assign dout = r_dout;
`else
  assign dout = w_ram_rdata;
`endif

  assign empty        = r_status.empty;
  assign full         = r_status.full;
  assign almost_empty = r_status.almost_empty;
  assign almost_full  = r_status.almost_full;
  assign overflow     = r_status.overflow;
  assign underflow    = r_status.underflow;
  assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_sync_fifo_flags;
  import sync_fifo_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = cnt_width(DEPTH);

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, err_clr;
  logic [DW-1:0] din, dout;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DWIDTH   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: FIFO semantics on a queue, updated at each rising edge
  always @(posedge clk) begin
    bit wacc, racc;
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      wacc = wr_en && (q.size() < DEPTH);
      racc = rd_en && (q.size() > 0);
      m_ovf = (wr_en && !wacc) || (m_ovf && !err_clr);
      m_unf = (rd_en && !racc) || (m_unf && !err_clr);
      if (racc) begin
`ifdef SYNC_FIFO_FWFT_EN
        void'(q.pop_front());
`else
        m_dout = q.pop_front();
`endif
      end
      if (wacc) q.push_back(din);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("full",         32'(full),         32'(q.size() == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
      chk("count",        32'(count),        32'(q.size()));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      if (q.size() > 0) chk("dout_head", 32'(dout), 32'(q[0]));
`else
      chk("dout", 32'(dout), 32'(m_dout));
`endif
    end
  end

  // One clock of stimulus, inputs changed on the falling edge
  task automatic tick(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    err_clr = c;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_dout",  32'(dout), 32'd0);
    rst = 1'b0;

    // Fill with 1..16, then drain in order
    for (int i = 1; i <= 16; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    chk("t1_full",    32'(full),  32'd1);
    chk("t1_count16", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("t1_head", 32'(dout), 32'(i));
      tick(1'b0, '0, 1'b1, 1'b0);
`else
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("t1_dout", 32'(dout), 32'(i));
`endif
    end
    chk("t1_empty",  32'(empty), 32'd1);
    chk("t1_count0", 32'(count), 32'd0);

    // Overflow while full; 0xDEAD must never be stored
    for (int i = 0; i < 16; i++) tick(1'b1, 16'h0100 + DW'(i), 1'b0, 1'b0);
    repeat (3) tick(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("t2_ovf",   32'(overflow), 32'd1);
    chk("t2_count", 32'(count),    32'd16);
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      chk("t2_head", 32'(dout), 32'h0100 + 32'(i));
      tick(1'b0, '0, 1'b1, 1'b0);
`else
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("t2_dout", 32'(dout), 32'h0100 + 32'(i));
`endif
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Steady state at count 8 with simultaneous read/write, pointers wrap
    for (int i = 0; i < 8; i++) tick(1'b1, 16'h0200 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b1, 16'h0300 + DW'(i), 1'b1, 1'b0);
    chk("t3_count8", 32'(count), 32'd8);
`ifdef SYNC_FIFO_FWFT_EN
    chk("t3_head", 32'(dout), 32'h0320);
`else
    chk("t3_dout", 32'(dout), 32'h031F);
`endif
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1, 1'b0);
    chk("t3_empty", 32'(empty), 32'd1);

    // Threshold ramp up and back down
    for (int n = 1; n <= 16; n++) begin
      tick(1'b1, 16'h0400 + DW'(n), 1'b0, 1'b0);
      chk("t4_ae_up", 32'(almost_empty), 32'(n <= 2));
      chk("t4_af_up", 32'(almost_full),  32'(n >= 14));
    end
    for (int n = 15; n >= 0; n--) begin
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("t4_ae_dn", 32'(almost_empty), 32'(n <= 2));
      chk("t4_af_dn", 32'(almost_full),  32'(n >= 14));
    end

    // Underflow on empty; dout holds
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("t5_unf",   32'(underflow), 32'd1);
    chk("t5_empty", 32'(empty),     32'd1);
    chk("t5_dout_hold", 32'(dout),  32'h0410);
    tick(1'b1, 16'hBEEF, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("t5_fwft_dout",  32'(dout),  32'hBEEF);
    chk("t5_fwft_empty", 32'(empty), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0);
`else
    chk("t5_no_bypass", 32'(dout), 32'h0410);
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("t5_dout_beef", 32'(dout), 32'hBEEF);
`endif

    // Reset mid-operation discards contents and clears sticky errors
    for (int i = 0; i < 5; i++) tick(1'b1, 16'h0500 + DW'(i), 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b1, 16'h05FF, 1'b1, 1'b0);
    rst = 1'b0;
    chk("t6_count", 32'(count),     32'd0);
    chk("t6_empty", 32'(empty),     32'd1);
    chk("t6_unf",   32'(underflow), 32'd0);
    chk("t6_ovf",   32'(overflow),  32'd0);
    chk("t6_dout",  32'(dout),      32'd0);
    tick(1'b1, 16'hA5A5, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("t6_head", 32'(dout), 32'hA5A5);
    tick(1'b0, '0, 1'b1, 1'b0);
`else
    tick(1'b0, '0, 1'b1, 1'b0);
    chk("t6_new_word", 32'(dout), 32'hA5A5);
`endif
    chk("t6_empty_end", 32'(empty), 32'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
